// File: rtl/watchdog_pkg.sv
// Shared sizing helpers and arithmetic functions for the commit watchdog.
// The helpers work on a fixed 64-bit container, so callers zero-extend their operands first.
package watchdog_pkg;

    localparam int unsigned MAX_W = 64;

    function automatic int unsigned core_id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Increment that holds at the all-ones value of a w-bit field.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] lim;
        lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return (v >= lim) ? lim : v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/watchdog_lane.sv
// Per-core stall tracker: idle-cycle counter, trip compare and commit popcount.
// The counter clears on a real commit or while disabled, and otherwise counts up with saturation.
module watchdog_lane
    import watchdog_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 6,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned POP_W       = count_w(COMMIT_WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] lanes,
    input  logic                    is_walk,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        timeout,
    output logic [CNT_W-1:0]        stall_next_c,
    output logic                    trip_c,
    output logic [POP_W-1:0]        commit_count_c
);

    logic [CNT_W-1:0] stall_cnt;
    logic             commit_c;

    always_comb begin
        commit_c       = !is_walk && (|lanes);
        commit_count_c = is_walk ? '0 : POP_W'(popcount(MAX_W'(lanes)));
        stall_next_c   = (commit_c || !enable) ? '0
                                               : CNT_W'(sat_inc(MAX_W'(stall_cnt), CNT_W));
        // Trip looks at the registered count so hang lands one edge after the limit is reached.
        trip_c         = enable && (timeout != '0) && (stall_cnt >= timeout);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_next_c;
        end
    end

endmodule

// File: rtl/commit_watchdog.sv
// Hang detector over the ROB commit ports of several cores, with a sticky first-hang record
// and a running count of committed instructions.
module commit_watchdog
    import watchdog_pkg::*;
#(
    parameter int unsigned NUM_CORES    = 2,
    parameter int unsigned COMMIT_WIDTH = 6,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned TOTAL_W      = 64,
    localparam int unsigned CORE_ID_W   = core_id_w(NUM_CORES)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [CNT_W-1:0]                  timeout_cycles,
    input  logic [NUM_CORES*COMMIT_WIDTH-1:0] commit_valid,
    input  logic [NUM_CORES-1:0]              commit_is_walk,
    output logic                              hang,
    output logic                              hang_pulse,
    output logic [CORE_ID_W-1:0]              hang_core,
    output logic [CNT_W-1:0]                  stall_max,
    output logic [TOTAL_W-1:0]                total_commits
);

    localparam int unsigned POP_W = count_w(COMMIT_WIDTH);

    logic [CNT_W-1:0]     stall_next_c [NUM_CORES];
    logic [POP_W-1:0]     commit_count_c [NUM_CORES];
    logic [NUM_CORES-1:0] trip_c;

    logic                 any_trip_c;
    logic [CORE_ID_W-1:0] first_core_c;
    logic [CNT_W-1:0]     max_next_c;
    logic [TOTAL_W-1:0]   sum_c;

    for (genvar c = 0; c < int'(NUM_CORES); c++) begin : g_core
        watchdog_lane #(
            .COMMIT_WIDTH (COMMIT_WIDTH),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clock          (clock),
            .reset          (reset),
            .lanes          (commit_valid[c*COMMIT_WIDTH +: COMMIT_WIDTH]),
            .is_walk        (commit_is_walk[c]),
            .enable         (enable),
            .timeout        (timeout_cycles),
            .stall_next_c   (stall_next_c[c]),
            .trip_c         (trip_c[c]),
            .commit_count_c (commit_count_c[c])
        );
    end

    // Lowest-index tripping core wins; max and sum are taken over next-state values.
    always_comb begin
        any_trip_c   = 1'b0;
        first_core_c = '0;
        max_next_c   = '0;
        sum_c        = '0;
        for (int c = int'(NUM_CORES) - 1; c >= 0; c--) begin
            if (trip_c[c]) begin
                any_trip_c   = 1'b1;
                first_core_c = CORE_ID_W'(c);
            end
        end
        for (int c = 0; c < int'(NUM_CORES); c++) begin
            if (stall_next_c[c] > max_next_c) begin
                max_next_c = stall_next_c[c];
            end
            sum_c = sum_c + TOTAL_W'(commit_count_c[c]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hang          <= 1'b0;
            hang_pulse    <= 1'b0;
            hang_core     <= '0;
            stall_max     <= '0;
            total_commits <= '0;
        end else begin
            hang_pulse    <= !hang && any_trip_c;
            stall_max     <= max_next_c;
            total_commits <= total_commits + sum_c;
            if (!hang && any_trip_c) begin
                hang      <= 1'b1;
                hang_core <= first_core_c;
            end
        end
    end

endmodule

// File: tb/tb_commit_watchdog.sv
// Randomised and directed check of commit_watchdog against a queue-based scoreboard.
module tb_commit_watchdog;

    localparam int unsigned NC      = 2;
    localparam int unsigned CW      = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TOTAL_W = 12;
    localparam int unsigned CNT_MAX = 255;
    localparam longint     TOT_MOD = 4096;

    logic               clock;
    logic               reset;
    logic               enable;
    logic [CNT_W-1:0]   timeout_cycles;
    logic [NC*CW-1:0]   commit_valid;
    logic [NC-1:0]      commit_is_walk;
    logic               hang;
    logic               hang_pulse;
    logic [0:0]         hang_core;
    logic [CNT_W-1:0]   stall_max;
    logic [TOTAL_W-1:0] total_commits;

    commit_watchdog #(
        .NUM_CORES    (NC),
        .COMMIT_WIDTH (CW),
        .CNT_W        (CNT_W),
        .TOTAL_W      (TOTAL_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .timeout_cycles (timeout_cycles),
        .commit_valid   (commit_valid),
        .commit_is_walk (commit_is_walk),
        .hang           (hang),
        .hang_pulse     (hang_pulse),
        .hang_core      (hang_core),
        .stall_max      (stall_max),
        .total_commits  (total_commits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        longint hang;
        longint pulse;
        longint core;
        longint smax;
        longint total;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     vectors = 0;
    int     miscompares = 0;

    // Reference state: idle run length per core, first-hang record, running total.
    longint m_idle[NC];
    bit     m_hang;
    longint m_core;
    longint m_total;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compute the expected post-edge outputs, queue them, then let the edge happen.
    task automatic tick();
        exp_t   e;
        bit     found;
        longint first;
        longint lanes;
        if (reset) begin
            for (int c = 0; c < int'(NC); c++) m_idle[c] = 0;
            m_hang  = 0;
            m_core  = 0;
            m_total = 0;
            e.pulse = 0;
        end else begin
            found = 0;
            first = 0;
            for (int c = 0; c < int'(NC); c++) begin
                if (!found && enable && timeout_cycles != 0 && m_idle[c] >= longint'(timeout_cycles)) begin
                    found = 1;
                    first = c;
                end
            end
            e.pulse = (found && !m_hang) ? 1 : 0;
            if (found && !m_hang) begin
                m_hang = 1;
                m_core = first;
            end
            for (int c = 0; c < int'(NC); c++) begin
                lanes = longint'(commit_valid[c*CW +: CW]);
                if ((!commit_is_walk[c] && lanes != 0) || !enable) m_idle[c] = 0;
                else m_idle[c] = (m_idle[c] + 1 > CNT_MAX) ? CNT_MAX : m_idle[c] + 1;
                if (!commit_is_walk[c]) m_total += $countones(commit_valid[c*CW +: CW]);
            end
            m_total = m_total % TOT_MOD;
        end
        e.hang  = m_hang;
        e.core  = m_core;
        e.total = m_total;
        e.smax  = 0;
        for (int c = 0; c < int'(NC); c++) if (m_idle[c] > e.smax) e.smax = m_idle[c];
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        commit_valid = '0;
        commit_is_walk = '0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Monitor: one expected record per edge, compared away from the active edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (longint'(hang) != mon_e.hang) begin
                miscompares++;
                $display("FAIL sb_hang: got %0d expected %0d at %0t", hang, mon_e.hang, $time);
            end
            if (longint'(hang_pulse) != mon_e.pulse) begin
                miscompares++;
                $display("FAIL sb_pulse: got %0d expected %0d at %0t", hang_pulse, mon_e.pulse, $time);
            end
            if (longint'(hang_core) != mon_e.core) begin
                miscompares++;
                $display("FAIL sb_core: got %0d expected %0d at %0t", hang_core, mon_e.core, $time);
            end
            if (longint'(stall_max) != mon_e.smax) begin
                miscompares++;
                $display("FAIL sb_stall_max: got %0d expected %0d at %0t", stall_max, mon_e.smax, $time);
            end
            if (longint'(total_commits) != mon_e.total) begin
                miscompares++;
                $display("FAIL sb_total: got %0d expected %0d at %0t", total_commits, mon_e.total, $time);
            end
        end
    end

    initial begin
        longint s0;
        logic [CW-1:0] l0;
        reset          = 1'b1;
        enable         = 1'b1;
        timeout_cycles = CNT_W'(10);
        commit_valid   = '0;
        commit_is_walk = '0;

        // Reset state
        do_reset(2);
        check("reset_hang", longint'(hang), 0);
        check("reset_total", longint'(total_commits), 0);

        // Basic timeout with a tie between both cores
        repeat (10) tick();
        check("basic_cnt10", longint'(stall_max), 10);
        check("basic_no_hang_yet", longint'(hang), 0);
        tick();
        check("basic_hang", longint'(hang), 1);
        check("basic_pulse", longint'(hang_pulse), 1);
        check("basic_core_tie", longint'(hang_core), 0);
        tick();
        check("basic_pulse_drop", longint'(hang_pulse), 0);

        // Walking core never counts as committing
        do_reset(1);
        s0 = 0;
        commit_is_walk = 2'b10;
        repeat (11) begin
            l0 = CW'($urandom_range(1, 63));
            commit_valid = {CW'($urandom_range(1, 63)), l0};
            s0 += $countones(l0);
            tick();
        end
        check("walk_hang", longint'(hang), 1);
        check("walk_core", longint'(hang_core), 1);
        check("walk_total", longint'(total_commits), s0 % TOT_MOD);
        commit_is_walk = '0;

        // Popcount across lanes and cores
        do_reset(1);
        commit_valid = {6'b000010, 6'b101101};
        repeat (3) tick();
        check("popcount_total", longint'(total_commits), 15);
        commit_valid = {6'b000001, 6'b000000};
        repeat (4) tick();
        check("lane5_before", longint'(stall_max), 4);
        commit_valid = {6'b000001, 6'b100000};
        tick();
        check("lane5_clears", longint'(stall_max), 0);

        // Enable low and zero timeout both suppress detection
        do_reset(1);
        commit_valid = '0;
        enable = 1'b0;
        repeat (50) tick();
        check("disabled_no_hang", longint'(hang), 0);
        check("disabled_stall_max", longint'(stall_max), 0);
        enable = 1'b1;
        timeout_cycles = '0;
        repeat (100) tick();
        check("tmo0_no_hang", longint'(hang), 0);
        timeout_cycles = CNT_W'(5);
        tick();
        check("tmo_lowered_hang", longint'(hang), 1);
        check("tmo_lowered_core", longint'(hang_core), 0);

        // Sticky flag and first-core record survive later events
        commit_valid = {6'b000000, 6'b000001};
        repeat (12) tick();
        check("sticky_hang", longint'(hang), 1);
        check("sticky_core", longint'(hang_core), 0);
        check("sticky_no_pulse", longint'(hang_pulse), 0);
        do_reset(1);
        check("midhang_reset_hang", longint'(hang), 0);
        check("midhang_reset_stall", longint'(stall_max), 0);

        // Saturation of the stall counter
        commit_valid = '0;
        timeout_cycles = '0;
        repeat (300) tick();
        check("saturate", longint'(stall_max), 255);

        // Wrap of the total counter
        do_reset(1);
        commit_valid = {6'b000000, 6'b000001};
        repeat (4097) tick();
        check("total_wrap", longint'(total_commits), 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) timeout_cycles = CNT_W'($urandom_range(0, 20));
            for (int c = 0; c < int'(NC); c++) begin
                commit_valid[c*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 63)) : '0;
                commit_is_walk[c] = ($urandom_range(0, 5) == 0);
            end
            tick();
        end
        reset = 1'b0;

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expected %0d pending records", exp_q.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
